// File: rtl/stream_chk_bank.sv
// Multi-channel write-stream checker: replays preloaded expected words against monitored streams.
// Optional first-mismatch capture is built when STREAM_CHK_CAPTURE_EN is defined.
module stream_chk_bank #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 96,
    parameter int REF_DEPTH  = 64,
    parameter int CNT_WIDTH  = 16,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW = $clog2(REF_DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr_all,
    input  logic                         ld_en,
    input  logic [CW-1:0]                ld_ch,
    input  logic [DATA_WIDTH-1:0]        ld_data,
    input  logic [NUM_CH-1:0]            rewind,
    input  logic [NUM_CH-1:0]            mon_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] mon_data,
    output logic [NUM_CH*CNT_WIDTH-1:0]  chk_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]  err_cnt,
    output logic [NUM_CH-1:0]            mis_pulse,
    output logic [NUM_CH-1:0]            underrun,
    output logic [NUM_CH-1:0]            overflow,
    output logic                         fe_valid,
    output logic [CW-1:0]                fe_ch,
    output logic [AW-1:0]                fe_idx,
    output logic [DATA_WIDTH-1:0]        fe_exp,
    output logic [DATA_WIDTH-1:0]        fe_act
);

    localparam logic [AW:0] DEPTH_P = (AW+1)'(REF_DEPTH);

`ifdef STREAM_CHK_CAPTURE_EN
    logic [NUM_CH-1:0]     mis_now;
    logic [DATA_WIDTH-1:0] exp_w [NUM_CH];
    logic [DATA_WIDTH-1:0] act_w [NUM_CH];
    logic [AW-1:0]         idx_w [NUM_CH];
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [AW:0]           wp_q, wp_d, rp_q, rp_d;
        logic [CNT_WIDTH-1:0]  chk_q, chk_d, err_q, err_d;
        logic                  mis_q, mis_d, und_q, und_d, ovf_q, ovf_d;
        logic [DATA_WIDTH-1:0] mem [REF_DEPTH];
        logic [DATA_WIDTH-1:0] exp_word, act_word;
        logic                  ld_hit, ld_room, wr_mem, avail, sample, mism;

        assign ld_hit   = ld_en && (ld_ch == CW'(gi));
        assign ld_room  = wp_q < DEPTH_P;
        assign wr_mem   = !clr_all && ld_hit && ld_room;
        assign exp_word = mem[rp_q[AW-1:0]];
        assign act_word = mon_data[gi*DATA_WIDTH +: DATA_WIDTH];
        // Compare against the pre-load wp: a word loaded this cycle is not yet available.
        assign avail    = rp_q < wp_q;
        assign sample   = mon_en[gi] && !rewind[gi];
        assign mism     = sample && avail && (act_word != exp_word);

        always_ff @(posedge clk) begin
            if (wr_mem) begin
                mem[wp_q[AW-1:0]] <= ld_data;
            end
        end

        always_comb begin
            wp_d  = wp_q;
            rp_d  = rp_q;
            chk_d = chk_q;
            err_d = err_q;
            mis_d = 1'b0;
            und_d = und_q;
            ovf_d = ovf_q;
            if (clr_all) begin
                wp_d  = '0;
                rp_d  = '0;
                chk_d = '0;
                err_d = '0;
                und_d = 1'b0;
                ovf_d = 1'b0;
            end else begin
                if (ld_hit) begin
                    if (ld_room) wp_d = wp_q + 1'b1;
                    else         ovf_d = 1'b1;
                end
                if (rewind[gi]) begin
                    rp_d = '0;
                end else if (mon_en[gi]) begin
                    if (avail) begin
                        rp_d = rp_q + 1'b1;
                        if (chk_q != '1) chk_d = chk_q + 1'b1;
                        if (mism) begin
                            mis_d = 1'b1;
                            if (err_q != '1) err_d = err_q + 1'b1;
                        end
                    end else begin
                        und_d = 1'b1;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wp_q  <= '0;
                rp_q  <= '0;
                chk_q <= '0;
                err_q <= '0;
                mis_q <= 1'b0;
                und_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                wp_q  <= wp_d;
                rp_q  <= rp_d;
                chk_q <= chk_d;
                err_q <= err_d;
                mis_q <= mis_d;
                und_q <= und_d;
                ovf_q <= ovf_d;
            end
        end

        assign chk_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = chk_q;
        assign err_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = err_q;
        assign mis_pulse[gi] = mis_q;
        assign underrun[gi]  = und_q;
        assign overflow[gi]  = ovf_q;

`ifdef STREAM_CHK_CAPTURE_EN
        assign mis_now[gi] = mism;
        assign exp_w[gi]   = exp_word;
        assign act_w[gi]   = act_word;
        assign idx_w[gi]   = rp_q[AW-1:0];
`endif
    end

`ifdef STREAM_CHK_CAPTURE_EN
    logic                  fe_valid_q, fe_valid_d;
    logic [CW-1:0]         fe_ch_q, fe_ch_d;
    logic [AW-1:0]         fe_idx_q, fe_idx_d;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;

    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_ch_d    = fe_ch_q;
        fe_idx_d   = fe_idx_q;
        fe_exp_d   = fe_exp_q;
        fe_act_d   = fe_act_q;
        if (clr_all) begin
            fe_valid_d = 1'b0;
            fe_ch_d    = '0;
            fe_idx_d   = '0;
            fe_exp_d   = '0;
            fe_act_d   = '0;
        end else if (!fe_valid_q && (|mis_now)) begin
            fe_valid_d = 1'b1;
            // Scan downward so the lowest mismatching channel is the last writer.
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (mis_now[c]) begin
                    fe_ch_d  = CW'(c);
                    fe_idx_d = idx_w[c];
                    fe_exp_d = exp_w[c];
                    fe_act_d = act_w[c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_valid_q <= 1'b0;
            fe_ch_q    <= '0;
            fe_idx_q   <= '0;
            fe_exp_q   <= '0;
            fe_act_q   <= '0;
        end else begin
            fe_valid_q <= fe_valid_d;
            fe_ch_q    <= fe_ch_d;
            fe_idx_q   <= fe_idx_d;
            fe_exp_q   <= fe_exp_d;
            fe_act_q   <= fe_act_d;
        end
    end

    assign fe_valid = fe_valid_q;
    assign fe_ch    = fe_ch_q;
    assign fe_idx   = fe_idx_q;
    assign fe_exp   = fe_exp_q;
    assign fe_act   = fe_act_q;
`else
    assign fe_valid = 1'b0;
    assign fe_ch    = '0;
    assign fe_idx   = '0;
    assign fe_exp   = '0;
    assign fe_act   = '0;
`endif

endmodule

// File: tb/tb_stream_chk_bank.sv
// Directed table-driven bench for stream_chk_bank with hand sequences for overflow and mid-stream reset.
module tb_stream_chk_bank;

    localparam int NUM_CH = 4;
    localparam int DW     = 96;
    localparam int DEPTH  = 64;
    localparam int CNTW   = 16;
    localparam int CW     = 2;
    localparam int AW     = 6;

`ifdef STREAM_CHK_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clr_all;
    logic                 ld_en;
    logic [CW-1:0]        ld_ch;
    logic [DW-1:0]        ld_data;
    logic [NUM_CH-1:0]    rewind;
    logic [NUM_CH-1:0]    mon_en;
    logic [NUM_CH*DW-1:0] mon_data;
    logic [NUM_CH*CNTW-1:0] chk_cnt, err_cnt;
    logic [NUM_CH-1:0]    mis_pulse, underrun, overflow;
    logic                 fe_valid;
    logic [CW-1:0]        fe_ch;
    logic [AW-1:0]        fe_idx;
    logic [DW-1:0]        fe_exp, fe_act;

    stream_chk_bank #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .REF_DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .reset(reset), .clr_all(clr_all), .ld_en(ld_en), .ld_ch(ld_ch),
        .ld_data(ld_data), .rewind(rewind), .mon_en(mon_en), .mon_data(mon_data),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt), .mis_pulse(mis_pulse), .underrun(underrun),
        .overflow(overflow), .fe_valid(fe_valid), .fe_ch(fe_ch), .fe_idx(fe_idx),
        .fe_exp(fe_exp), .fe_act(fe_act)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            clr;
        logic            ld;
        logic [1:0]      lch;
        logic [15:0]     ld_d;
        logic [3:0]      rew;
        logic [3:0]      men;
        logic [3:0][15:0] md;
        logic [1:0]      cc;
        logic [15:0]     e_chk;
        logic [15:0]     e_err;
        logic [3:0]      e_mis;
        logic [3:0]      e_und;
        logic [3:0]      e_ovf;
        logic            e_fev;
        logic [1:0]      e_fech;
        logic [5:0]      e_feidx;
        logic [15:0]     e_feexp;
        logic [15:0]     e_feact;
    } vec_t;

    vec_t vecs [48];
    int   n_vec = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic clr, input logic ld, input logic [1:0] lch, input logic [15:0] ldd,
                       input logic [3:0] rew, input logic [3:0] men,
                       input logic [15:0] m0, input logic [15:0] m1, input logic [15:0] m2, input logic [15:0] m3,
                       input logic [1:0] cc, input logic [15:0] ec, input logic [15:0] ee,
                       input logic [3:0] emis, input logic [3:0] eund, input logic [3:0] eovf,
                       input logic fev, input logic [1:0] fech, input logic [5:0] feidx,
                       input logic [15:0] feexp, input logic [15:0] feact);
        vec_t v;
        v.clr = clr; v.ld = ld; v.lch = lch; v.ld_d = ldd; v.rew = rew; v.men = men;
        v.md = {m3, m2, m1, m0};
        v.cc = cc; v.e_chk = ec; v.e_err = ee; v.e_mis = emis; v.e_und = eund; v.e_ovf = eovf;
        v.e_fev = fev; v.e_fech = fech; v.e_feidx = feidx; v.e_feexp = feexp; v.e_feact = feact;
        vecs[n_vec] = v;
        n_vec++;
    endtask

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        clr_all = 1'b0; ld_en = 1'b0; ld_ch = '0; ld_data = '0;
        rewind = '0; mon_en = '0; mon_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ovf_word(input int i);
        logic [15:0] k;
        k = 16'(i);
        return {k, 64'hDEAD_BEEF_0123_4567, ~k};
    endfunction

    initial begin
        logic mis_seen;

        // T1: clean stream on ch0
        add(0,1,0,16'h1, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,0,16'h2, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,0,16'h3, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h1,0,0,0, 0,1,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h2,0,0,0, 0,2,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h3,0,0,0, 0,3,0, 0,0,0, 0,0,0,0,0);
        // T2: mismatch on ch1 second word becomes first error
        add(0,1,1,16'hA, 0,0, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,1,16'hB, 0,0, 0,0,0,0, 1,0,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0010, 0,16'hA,0,0, 1,1,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0010, 0,16'hC,0,0, 1,2,1, 4'b0010,0,0, 1,1,1,16'hB,16'hC);
        add(0,0,0,0, 0,0, 0,0,0,0, 1,2,1, 0,0,0, 1,1,1,16'hB,16'hC);
        // T3: simultaneous mismatches on ch2/ch3, lowest wins; later mismatch ignored
        add(1,0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,2,16'h20, 0,0, 0,0,0,0, 2,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,3,16'h30, 0,0, 0,0,0,0, 2,0,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b1100, 0,0,16'h21,16'h31, 2,1,1, 4'b1100,0,0, 1,2,0,16'h20,16'h21);
        add(0,1,3,16'h32, 0,0, 0,0,0,0, 3,1,1, 0,0,0, 1,2,0,16'h20,16'h21);
        add(0,0,0,0, 0,4'b1000, 0,0,0,16'h33, 3,2,2, 4'b1000,0,0, 1,2,0,16'h20,16'h21);
        // T4: underrun on ch0, then rewind (beats mon_en) and replay
        add(1,0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,0,16'h5, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,0,16'h6, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h5,0,0,0, 0,1,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h6,0,0,0, 0,2,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h7,0,0,0, 0,2,1, 0,4'b0001,0, 0,0,0,0,0);
        add(0,0,0,0, 4'b0001,4'b0001, 16'h99,0,0,0, 0,2,1, 0,4'b0001,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h5,0,0,0, 0,3,1, 0,4'b0001,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0001, 16'h6,0,0,0, 0,4,1, 0,4'b0001,0, 0,0,0,0,0);
        // T5: same-cycle load+check uses pre-load wp; rewind[1]+mon_en[1]
        add(1,0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,1,16'h40, 0,4'b0010, 0,16'h40,0,0, 1,0,1, 0,4'b0010,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0010, 0,16'h40,0,0, 1,1,1, 0,4'b0010,0, 0,0,0,0,0);
        add(0,0,0,0, 4'b0010,4'b0010, 0,16'h55,0,0, 1,1,1, 0,4'b0010,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0010, 0,16'h40,0,0, 1,2,1, 0,4'b0010,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0010, 0,16'h41,0,0, 1,2,2, 0,4'b0010,0, 0,0,0,0,0);
        // T6: back-to-back mismatches hold mis_pulse high
        add(1,0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,2,16'h1, 0,0, 0,0,0,0, 2,0,0, 0,0,0, 0,0,0,0,0);
        add(0,1,2,16'h2, 0,0, 0,0,0,0, 2,0,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,4'b0100, 0,0,16'h9,0, 2,1,1, 4'b0100,0,0, 1,2,0,16'h1,16'h9);
        add(0,0,0,0, 0,4'b0100, 0,0,16'h8,0, 2,2,2, 4'b0100,0,0, 1,2,0,16'h1,16'h9);
        add(0,0,0,0, 0,0, 0,0,0,0, 2,2,2, 0,0,0, 1,2,0,16'h1,16'h9);

        idle_inputs();
        reset = 1'b1;
        #1;
        check("reset_chk_cnt", DW'(chk_cnt), '0);
        check("reset_err_cnt", DW'(err_cnt), '0);
        check("reset_flags", DW'({mis_pulse, underrun, overflow}), '0);
        check("reset_fe_valid", DW'(fe_valid), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            vec_t v;
            int c;
            v = vecs[i];
            @(negedge clk);
            clr_all = v.clr; ld_en = v.ld; ld_ch = v.lch; ld_data = DW'(v.ld_d);
            rewind = v.rew; mon_en = v.men;
            for (int k = 0; k < NUM_CH; k++) mon_data[k*DW +: DW] = DW'(v.md[k]);
            tick();
            c = int'(v.cc);
            $display("vec %0d: clr=%0b ld=%0b/%0d/%0h rew=%b men=%b ch%0d chk=%0d err=%0d mis=%b und=%b",
                     i, v.clr, v.ld, v.lch, v.ld_d, v.rew, v.men, c,
                     chk_cnt[c*CNTW +: CNTW], err_cnt[c*CNTW +: CNTW], mis_pulse, underrun);
            check($sformatf("v%0d_chk_cnt", i), DW'(chk_cnt[c*CNTW +: CNTW]), DW'(v.e_chk));
            check($sformatf("v%0d_err_cnt", i), DW'(err_cnt[c*CNTW +: CNTW]), DW'(v.e_err));
            check($sformatf("v%0d_mis_pulse", i), DW'(mis_pulse), DW'(v.e_mis));
            check($sformatf("v%0d_underrun", i), DW'(underrun), DW'(v.e_und));
            check($sformatf("v%0d_overflow", i), DW'(overflow), DW'(v.e_ovf));
            check($sformatf("v%0d_fe_valid", i), DW'(fe_valid), CAP ? DW'(v.e_fev) : '0);
            check($sformatf("v%0d_fe_ch", i), DW'(fe_ch), CAP ? DW'(v.e_fech) : '0);
            check($sformatf("v%0d_fe_idx", i), DW'(fe_idx), CAP ? DW'(v.e_feidx) : '0);
            check($sformatf("v%0d_fe_exp", i), fe_exp, CAP ? DW'(v.e_feexp) : '0);
            check($sformatf("v%0d_fe_act", i), fe_act, CAP ? DW'(v.e_feact) : '0);
        end

        // Overflow: REF_DEPTH+1 loads into ch3, then check exactly REF_DEPTH words
        @(negedge clk); idle_inputs(); clr_all = 1'b1; tick();
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk); idle_inputs();
            ld_en = 1'b1; ld_ch = 2'd3; ld_data = ovf_word(i);
            tick();
        end
        $display("ovf: loaded %0d words into ch3, overflow=%b", DEPTH + 1, overflow);
        check("ovf_flag", DW'(overflow), DW'(4'b1000));
        check("ovf_no_underrun", DW'(underrun), '0);
        mis_seen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); idle_inputs();
            mon_en = 4'b1000; mon_data[3*DW +: DW] = ovf_word(i);
            tick();
            mis_seen = mis_seen | mis_pulse[3];
        end
        $display("ovf: checked %0d words chk=%0d err=%0d", DEPTH, chk_cnt[3*CNTW +: CNTW], err_cnt[3*CNTW +: CNTW]);
        check("ovf_chk_cnt", DW'(chk_cnt[3*CNTW +: CNTW]), DW'(DEPTH));
        check("ovf_err_cnt", DW'(err_cnt[3*CNTW +: CNTW]), '0);
        check("ovf_mis_seen", DW'(mis_seen), '0);
        @(negedge clk); idle_inputs();
        mon_en = 4'b1000; mon_data[3*DW +: DW] = ovf_word(DEPTH);
        tick();
        $display("ovf: extra sample underrun=%b", underrun);
        check("ovf_extra_underrun", DW'(underrun), DW'(4'b1000));
        check("ovf_extra_chk_cnt", DW'(chk_cnt[3*CNTW +: CNTW]), DW'(DEPTH));
        check("ovf_extra_err_cnt", DW'(err_cnt[3*CNTW +: CNTW]), DW'(1));

        // Asynchronous reset in the middle of a check stream
        @(negedge clk); idle_inputs(); clr_all = 1'b1; tick();
        @(negedge clk); idle_inputs(); ld_en = 1'b1; ld_ch = 2'd0; ld_data = DW'(16'h11); tick();
        @(negedge clk); idle_inputs(); ld_en = 1'b1; ld_ch = 2'd0; ld_data = DW'(16'h12); tick();
        @(negedge clk); idle_inputs(); mon_en = 4'b0001; mon_data[DW-1:0] = DW'(16'h11); tick();
        check("pre_rst_chk_cnt", DW'(chk_cnt[CNTW-1:0]), DW'(1));
        @(negedge clk); idle_inputs(); mon_en = 4'b0001; mon_data[DW-1:0] = DW'(16'h13);
        #2 reset = 1'b1;
        #1;
        $display("rst: mid-stream reset chk=%0h err=%0h flags=%b", chk_cnt, err_cnt, {mis_pulse, underrun, overflow});
        check("midrst_chk_cnt", DW'(chk_cnt), '0);
        check("midrst_err_cnt", DW'(err_cnt), '0);
        check("midrst_flags", DW'({mis_pulse, underrun, overflow}), '0);
        check("midrst_fe", DW'({fe_valid, fe_ch, fe_idx}), '0);
        @(negedge clk); idle_inputs(); reset = 1'b0;
        mon_en = 4'b0001; mon_data[DW-1:0] = DW'(16'h11);
        tick();
        $display("rst: post-reset sample underrun=%b chk=%0d", underrun, chk_cnt[CNTW-1:0]);
        check("postrst_underrun", DW'(underrun), DW'(4'b0001));
        check("postrst_chk_cnt", DW'(chk_cnt[CNTW-1:0]), '0);
        @(negedge clk); idle_inputs(); ld_en = 1'b1; ld_ch = 2'd0; ld_data = DW'(16'h77); tick();
        @(negedge clk); idle_inputs(); mon_en = 4'b0001; mon_data[DW-1:0] = DW'(16'h77); tick();
        $display("rst: reload at index 0 chk=%0d err=%0d mis=%b", chk_cnt[CNTW-1:0], err_cnt[CNTW-1:0], mis_pulse);
        check("postrst_reload_chk", DW'(chk_cnt[CNTW-1:0]), DW'(1));
        check("postrst_reload_err", DW'(err_cnt[CNTW-1:0]), DW'(1));
        check("postrst_reload_mis", DW'(mis_pulse), '0);

        @(negedge clk); idle_inputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got hang, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stream_chk_bank.md
# stream_chk_bank

Synthesizable multi-channel write-stream checker for FPGA bring-up of the TS3D accelerator. It compares up to NUM_CH monitored write streams (enable + data, e.g. GBFFLGWEI/GBFWEI/GBFFLGACT/GBFACT writes) against per-channel expected sequences preloaded into on-chip reference buffers. It counts checks and mismatches, flags buffer over/underrun, and captures the first mismatch for readout. It sits beside TS3D in the FPGA top and taps the global-buffer write ports. A per-channel rewind restarts comparison at each layer/tile reset.

## Interface
Parameters:
- NUM_CH, 4, number of monitored streams
- DATA_WIDTH, 96, monitored data width (PORT_DATAWIDTH)
- REF_DEPTH, 64, expected words per channel (power of two)
- CNT_WIDTH, 16, check/error counter width
- Derived: CW = clog2(NUM_CH) (min 1), AW = clog2(REF_DEPTH)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- clr_all  in  1  synchronous clear of all pointers, counters and flags
- ld_en  in  1  load one expected word
- ld_ch  in  CW  channel to load
- ld_data  in  DATA_WIDTH  expected word
- rewind  in  NUM_CH  per-channel read-pointer reset (e.g. Reset_WEI/Reset_ACT pulses)
- mon_en  in  NUM_CH  per-channel monitored write enable
- mon_data  in  NUM_CH*DATA_WIDTH  monitored write data, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- chk_cnt  out  NUM_CH*CNT_WIDTH  words checked per channel
- err_cnt  out  NUM_CH*CNT_WIDTH  mismatches per channel
- mis_pulse  out  NUM_CH  one-cycle mismatch strobe
- underrun  out  NUM_CH  sticky: mon_en with no expected word left
- overflow  out  NUM_CH  sticky: load into full channel buffer
- fe_valid  out  1  first mismatch captured
- fe_ch  out  CW  channel of first mismatch
- fe_idx  out  AW  read index of first mismatch
- fe_exp  out  DATA_WIDTH  expected word
- fe_act  out  DATA_WIDTH  observed word

## Operation
- Per channel: REF_DEPTH x DATA_WIDTH buffer, write pointer wp (0..REF_DEPTH), read pointer rp (0..REF_DEPTH).
- Load: ld_en with wp[ld_ch] < REF_DEPTH stores ld_data at wp, wp+1. At wp == REF_DEPTH the word is dropped and overflow[ld_ch] sets. ld_ch >= NUM_CH is ignored.
- Check: mon_en[c] with rp < wp compares mon_data slice to buf[rp]. rp+1 and chk_cnt+1. On inequality, err_cnt+1 and mis_pulse[c] asserts.
- Underrun: mon_en[c] with rp == wp sets underrun[c] and increments err_cnt. rp and chk_cnt are unchanged, and mis_pulse does not assert.
- No wrap-around. rp stops at wp. Counters saturate at all-ones.
- rewind[c]: rp <= 0. wp, buffer, counters and flags are kept, so the same expected sequence is replayed.
- First-error capture: this is the first mismatch (not underrun) after reset/clr_all. If several channels mismatch in the same cycle, the lowest channel wins. The capture then holds until reset/clr_all.
- Precedence, same cycle:
  - clr_all beats everything.
  - rewind[c] beats mon_en[c]: the sample is ignored and not counted.
  - ld_en and mon_en on the same channel are both performed. The compare uses the pre-load wp, so a word being loaded is not yet checkable.

## Timing
- Reset (async) or clr_all (sync) clears the following to 0: wp, rp, chk_cnt, err_cnt, mis_pulse, underrun, overflow, fe_valid, fe_ch, fe_idx, fe_exp, fe_act. Buffer contents are not cleared.
- Buffer read is combinational at rp (distributed RAM). Compare and all state updates register on the same edge that samples mon_en.
- Latency: counters, flags, mis_pulse and fe_* are valid 1 cycle after the sampled mon_en edge.
- mis_pulse is high exactly one cycle per mismatching sample. Back-to-back mismatches give a continuous high.
- Reset asserted mid-stream aborts immediately. After release, the next load starts at index 0.
- Loaded word is checkable from the cycle after ld_en.

## Configuration
- STREAM_CHK_CAPTURE_EN defined: the first-error capture registers are built and fe_* behave as above.
- STREAM_CHK_CAPTURE_EN not defined: the capture registers are removed and fe_* outputs are tied to 0. Counters, mis_pulse and flags are unaffected.

## Test plan
- Load ch0 with 0x1,0x2,0x3; drive mon_en[0] with 0x1,0x2,0x3 -> chk_cnt[0]=3, err_cnt[0]=0, mis_pulse never high.
- Load ch1 0xA,0xB; observe 0xA,0xC -> err_cnt[1]=1, mis_pulse[1] high 1 cycle after the second sample. With capture enabled, fe_valid=1, fe_ch=1, fe_idx=1, fe_exp=0xB, fe_act=0xC.
- Same-cycle mismatches on ch2 and ch3 as the first error -> fe_ch=2. A later mismatch leaves fe_* unchanged.
- Load ch0 with 2 words; issue 3 mon_en -> chk_cnt=2, err_cnt=1, underrun[0]=1. Then rewind[0] plus a correct replay of 2 words -> chk_cnt=4.
- Load REF_DEPTH+1 words into ch3 -> overflow[3]=1, and the last word is not stored. Checking REF_DEPTH correct words gives err_cnt=0.
- rewind[1] and mon_en[1] in the same cycle -> chk_cnt unchanged, rp=0. Assert reset mid-check -> all outputs 0 immediately.
